// File: rtl/mult.sv
// mult: iterative radix-2 Booth multiplier producing a 2*WIDTH-bit product in HI/LO
module mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multControl,
    input  logic             signedOp,
    input  logic [WIDTH-1:0] aInput,
    input  logic [WIDTH-1:0] bInput,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             ok
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH+1:0] acc_q, acc_d, m_ext, sum;
    logic [WIDTH:0]   m_q, m_d, q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             ok_q, ok_d;
    // Booth add/subtract on the accumulator, then the next-state/control decisions
    always_comb begin
        m_ext   = {m_q[WIDTH], m_q};
        sum     = (q_q[0] & ~qm1_q) ? acc_q - m_ext :
                  (~q_q[0] & qm1_q) ? acc_q + m_ext : acc_q;
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ok_d    = ok_q;
        case (state_q)
            IDLE: if (multControl) begin
                m_d     = {signedOp & aInput[WIDTH-1], aInput};
                q_d     = {signedOp & bInput[WIDTH-1], bInput};
                acc_d   = '0;
                qm1_d   = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = RUN;
                ok_d    = 1'b0;
            end
            RUN: begin
                acc_d = {sum[WIDTH+1], sum[WIDTH+1:1]};
                q_d   = {sum[0], q_q[WIDTH:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    // low 2*WIDTH bits of the shifted {acc, Q} pair
                    {hi_d, lo_d} = {sum[WIDTH-1:0], q_q[WIDTH:1]};
                    state_d      = DONE;
                    ok_d         = 1'b1;
                end
            end
            DONE: if (!multControl) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state registers with synchronous reset clearing everything back to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ok_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ok_q    <= ok_d;
        end
    end
    assign HI = hi_q;
    assign LO = lo_q;
    assign ok = ok_q;
endmodule

// File: tb/tb_mult.sv
// tb_mult: randomized and directed checks of mult against an arithmetic product model
module tb_mult;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        multControl = 1'b0;
    logic        signedOp = 1'b0;
    logic [31:0] aInput = '0;
    logic [31:0] bInput = '0;
    logic [31:0] HI, LO;
    logic        ok;
    int vectors = 0;
    int errors = 0;

    mult #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .multControl(multControl), .signedOp(signedOp),
        .aInput(aInput), .bInput(bInput), .HI(HI), .LO(LO), .ok(ok)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        sa = s ? {{32{a[31]}}, a} : {32'b0, a};
        sb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return 64'(sa * sb);
    endfunction

    // start one operation, drop the request, wait for ok, then return to idle
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo);
        aInput = a;
        bInput = b;
        signedOp = s;
        multControl = 1'b1;
        tick();
        multControl = 1'b0;
        lat = 0;
        while (!ok && lat < 100) begin
            tick();
            lat++;
        end
        hi = HI;
        lo = LO;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        multControl = 1'b1;
        aInput = 32'd9;
        bInput = 32'd9;
        tick();
        reset = 1'b0;
        multControl = 1'b0;
        vectors++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", HI); end
        vectors++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", LO); end
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL reset_ok got %b want 1", ok); end
        tick();
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL reset_nostart_ok got %b want 1", ok); end
    endtask

    task automatic test_directed;
        logic [31:0] ta [5] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'd5};
        logic [31:0] tb [5] = '{32'hFFFFFFFF, 32'h00000003, 32'h80000000, 32'hFFFFFFFF, 32'd7};
        logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] tp [5] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB,
                                64'h40000000_00000000, 64'h1, 64'd35};
        int lat;
        logic [31:0] hi, lo;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], ts[i], lat, hi, lo);
            vectors++; if (lat !== 33) begin errors++; $display("FAIL dir%0d_latency got %0d want 33", i, lat); end
            vectors++; if ({hi, lo} !== tp[i]) begin errors++; $display("FAIL dir%0d_product got %h want %h", i, {hi, lo}, tp[i]); end
        end
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] a, b, hi, lo;
        logic s;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            a = $urandom();
            b = $urandom();
            if (i % 8 == 0) a = 32'h80000000;
            if (i % 8 == 1) b = 32'h0;
            if (i % 8 == 2) b = 32'h7FFFFFFF;
            s = 1'($urandom_range(0, 1));
            exp = ref_prod(a, b, s);
            do_op(a, b, s, lat, hi, lo);
            vectors++; if (lat !== 33) begin errors++; $display("FAIL rnd%0d_latency got %0d want 33", i, lat); end
            vectors++; if ({hi, lo} !== exp) begin errors++; $display("FAIL rnd%0d_product a=%h b=%h s=%b got %h want %h", i, a, b, s, {hi, lo}, exp); end
        end
    endtask

    task automatic test_midrun;
        int lat;
        logic [31:0] hi, lo;
        do_op(32'd5, 32'd7, 1'b0, lat, hi, lo);
        vectors++; if (lo !== 32'd35) begin errors++; $display("FAIL mid_prior got %0d want 35", lo); end
        aInput = 32'h12345678;
        bInput = 32'h10;
        signedOp = 1'b0;
        multControl = 1'b1;
        tick();
        lat = 0;
        while (!ok && lat < 100) begin
            if (lat == 5) begin
                aInput = $urandom();
                bInput = $urandom();
                signedOp = 1'b1;
                multControl = 1'b0;
            end
            vectors++; if (HI !== 32'd0 || LO !== 32'd35) begin errors++; $display("FAIL mid_hold c%0d got %h_%h want 0_23", lat, HI, LO); end
            tick();
            lat++;
        end
        vectors++; if (lat !== 33) begin errors++; $display("FAIL mid_latency got %0d want 33", lat); end
        vectors++; if ({HI, LO} !== 64'h00000001_23456780) begin errors++; $display("FAIL mid_product got %h want 0000000123456780", {HI, LO}); end
        tick();
    endtask

    task automatic test_reset_midrun;
        int lat;
        logic [31:0] hi, lo;
        aInput = 32'd9;
        bInput = 32'd9;
        multControl = 1'b1;
        tick();
        multControl = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL rstmid_running got ok=%b want 0", ok); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if ({ok, HI, LO} !== {1'b1, 64'd0}) begin errors++; $display("FAIL rstmid_abort got ok=%b %h_%h want 1 0_0", ok, HI, LO); end
        tick();
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_idle got ok=%b want 1", ok); end
        do_op(32'd3, 32'd4, 1'b0, lat, hi, lo);
        vectors++; if (lat !== 33) begin errors++; $display("FAIL rstmid_latency got %0d want 33", lat); end
        vectors++; if ({hi, lo} !== 64'd12) begin errors++; $display("FAIL rstmid_fresh got %h want 12", {hi, lo}); end
    endtask

    task automatic test_rearm;
        int lat;
        logic [31:0] a, b;
        logic [63:0] exp;
        a = $urandom();
        b = $urandom();
        exp = ref_prod(a, b, 1'b1);
        aInput = a;
        bInput = b;
        signedOp = 1'b1;
        multControl = 1'b1;
        tick();
        lat = 0;
        while (!ok && lat < 100) begin
            tick();
            lat++;
        end
        vectors++; if ({HI, LO} !== exp) begin errors++; $display("FAIL rearm_first got %h want %h", {HI, LO}, exp); end
        aInput = $urandom();
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++; if (ok !== 1'b1 || {HI, LO} !== exp) begin errors++; $display("FAIL rearm_hold%0d got ok=%b %h want 1 %h", i, ok, {HI, LO}, exp); end
        end
        multControl = 1'b0;
        tick();
        a = $urandom();
        b = $urandom();
        exp = ref_prod(a, b, 1'b0);
        aInput = a;
        bInput = b;
        signedOp = 1'b0;
        multControl = 1'b1;
        tick();
        vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL rearm_restart got ok=%b want 0", ok); end
        lat = 0;
        while (!ok && lat < 100) begin
            tick();
            lat++;
        end
        vectors++; if (lat !== 33) begin errors++; $display("FAIL rearm_latency got %0d want 33", lat); end
        vectors++; if ({HI, LO} !== exp) begin errors++; $display("FAIL rearm_second got %h want %h", {HI, LO}, exp); end
        multControl = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_directed();
        test_random();
        test_midrun();
        test_reset_midrun();
        test_rearm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
